// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the core's single memory port: data beats instruction,
// one transaction in flight, watchdog converts a silent memory into an error ack.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ack,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            stall,
  output logic            bus_error,
  input  logic            clr_error,
  output logic [1:0]      dbg_state
);

  // Handshake: a requester raises req (level) with stable payload and keeps it
  // until its ack pulses for one cycle; the memory side sees mem_req held high
  // with constant mem_* until mem_ack, which completes the access in that cycle.

  localparam int BW = DW / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]   mem_be_q, mem_be_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic [CW-1:0]   wd_cnt_q, wd_cnt_d;
  logic            bus_error_q, bus_error_d;

  logic            busy;
  logic            timeout_hit;
  logic            i_ack_c, d_ack_c, err_c;

  assign busy = (state_q != IDLE);
  // mem_ack arriving on the last allowed cycle takes precedence over the timeout.
  assign timeout_hit = WD_EN && busy && !mem_ack && (wd_cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    wd_cnt_d    = wd_cnt_q;
    bus_error_d = bus_error_q;
    i_ack_c     = 1'b0;
    d_ack_c     = 1'b0;
    err_c       = 1'b0;

    if (clr_error) begin
      bus_error_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        wd_cnt_d = '0;
        if (d_req) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
        end else if (i_req) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
        end
      end

      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          i_ack_c   = (state_q == BUSY_I);
          d_ack_c   = (state_q == BUSY_D);
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            if (state_q == BUSY_I) begin
              i_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = mem_rdata;
            end
          end
        end else if (timeout_hit) begin
          i_ack_c     = (state_q == BUSY_I);
          d_ack_c     = (state_q == BUSY_D);
          err_c       = 1'b1;
          bus_error_d = 1'b1;
          state_d     = IDLE;
          mem_req_d   = 1'b0;
        end else if (wd_cnt_q != CNT_MAX) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      wd_cnt_q    <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      wd_cnt_q    <= wd_cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign i_ack     = i_ack_c;
  assign d_ack     = d_ack_c;
  assign err       = err_c;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign bus_error = bus_error_q;
  assign dbg_state = state_q;
  // Drops in the ack cycle so the control unit advances on that same edge.
  assign stall     = (i_req & ~i_ack_c) | (d_req & ~d_ack_c);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model compared every cycle,
// plus literal expectations at key points of each scenario.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk, rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall, bus_error, clr_error;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .bus_error(bus_error), .clr_error(clr_error), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  int n_vec = 0;
  int n_err = 0;
  bit cmp_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: at most one transaction outstanding, tracked by its age in busy cycles.
  bit          m_active = 0;
  bit          m_is_d = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic        m_we = 0;
  logic [3:0]  m_be = 0;
  int          m_age = 0;
  logic [31:0] m_irdata = 0, m_drdata = 0;
  bit          m_buserr = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 0; m_age = 0; m_irdata = 0; m_drdata = 0; m_buserr = 0;
    end else begin
      bit tmo;
      tmo = m_active && !mem_ack && (m_age + 1 == TO);
      if (tmo) m_buserr = 1;
      else if (clr_error) m_buserr = 0;
      if (m_active) begin
        if (mem_ack) begin
          if (!m_we) begin
            if (m_is_d) m_drdata = mem_rdata;
            else m_irdata = mem_rdata;
          end
          m_active = 0;
        end else if (tmo) begin
          m_active = 0;
        end else begin
          m_age++;
        end
      end else if (d_req) begin
        m_active = 1; m_is_d = 1; m_addr = d_addr; m_we = d_we;
        m_wdata = d_wdata; m_be = d_be; m_age = 0;
      end else if (i_req) begin
        m_active = 1; m_is_d = 0; m_addr = i_addr; m_we = 0;
        m_wdata = 0; m_be = 4'hF; m_age = 0;
      end
    end
  end

  // scoreboard: every cycle, away from the active edge
  always @(negedge clk) begin
    if (cmp_on && rst) begin
      logic tmo, done, ei, ed;
      tmo = m_active && !mem_ack && (m_age + 1 == TO);
      done = m_active && (mem_ack || tmo);
      ei = done && !m_is_d;
      ed = done && m_is_d;
      chk("mem_req", mem_req, m_active);
      chk("i_ack", i_ack, ei);
      chk("d_ack", d_ack, ed);
      chk("err", err, tmo);
      chk("stall", stall, (i_req && !ei) || (d_req && !ed));
      chk("bus_error", bus_error, m_buserr);
      chk("i_rdata", i_rdata, m_irdata);
      chk("d_rdata", d_rdata, m_drdata);
      if (m_active) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_we", mem_we, m_we);
        chk("mem_be", mem_be, m_be);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  // driver: requesters drop req after their ack; memory acks on busy cycle ack_at
  bit tie_ack = 0;
  int ack_at = 0;
  int busy_n = 0;

  task automatic tick();
    logic ia, da;
    @(negedge clk);
    ia = i_ack;
    da = d_ack;
    @(posedge clk);
    #1;
    if (ia) i_req = 0;
    if (da) d_req = 0;
    if (mem_req) busy_n++;
    else busy_n = 0;
    mem_ack = tie_ack || (mem_req && ack_at != 0 && busy_n == ack_at);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst = 0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_be = 0; mem_ack = 0; mem_rdata = 0; clr_error = 0;
    ticks(2);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_bus_error", bus_error, 0);
    chk("rst_acks", {i_ack, d_ack, err, stall}, 0);
    rst = 1;
    cmp_on = 1;
    tick();

    // instruction read, memory answers on the 3rd busy cycle
    ack_at = 3; mem_rdata = 32'h0050_0093;
    i_req = 1; i_addr = 32'h100;
    #1 chk("ifetch_stall_wait", stall, 1);
    tick();
    chk("ifetch_addr", mem_addr, 32'h100);
    chk("ifetch_be", mem_be, 4'hF);
    chk("ifetch_we", mem_we, 0);
    chk("ifetch_stall_busy", stall, 1);
    ticks(2);
    chk("ifetch_ack", i_ack, 1);
    chk("ifetch_err", err, 0);
    chk("ifetch_stall_ack", stall, 0);
    tick();
    chk("ifetch_ack_gone", i_ack, 0);
    chk("ifetch_rdata", i_rdata, 32'h0050_0093);

    // collision: data write wins, one idle cycle, then the fetch
    ack_at = 2; mem_rdata = 32'h1111_1111;
    i_req = 1; i_addr = 32'h104;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    tick();
    chk("coll_we", mem_we, 1);
    chk("coll_be", mem_be, 4'b0011);
    chk("coll_addr", mem_addr, 32'h2000);
    chk("coll_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("coll_d_ack", d_ack, 1);
    chk("coll_i_wait", {i_ack, stall}, 2'b01);
    tick();
    chk("coll_idle_gap", mem_req, 0);
    tick();
    chk("coll_i_addr", mem_addr, 32'h104);
    chk("coll_i_be", mem_be, 4'hF);
    ticks(2);
    chk("coll_i_rdata", i_rdata, 32'h1111_1111);
    chk("coll_d_rdata_kept", d_rdata, 0);

    // zero-wait memory: mem_ack tied high, never acked while idle
    tie_ack = 1; mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    #1 chk("zw_idle_acks", {i_ack, d_ack, err}, 0);
    tick();
    chk("zw_idle_acks2", {i_ack, d_ack, err}, 0);
    d_req = 1; d_we = 0; d_addr = 32'h3000; d_be = 4'hF;
    tick();
    chk("zw_d_ack", d_ack, 1);
    tick();
    chk("zw_d_rdata", d_rdata, 32'hCAFE_F00D);
    chk("zw_idle_after", {d_ack, mem_req}, 0);
    i_req = 1; i_addr = 32'h108; mem_rdata = 32'h0000_0013;
    tick();
    chk("zw_i_ack", i_ack, 1);
    tick();
    chk("zw_i_rdata", i_rdata, 32'h0000_0013);
    tie_ack = 0; mem_ack = 0;

    // timeout on a data read that memory ignores
    ack_at = 0; mem_rdata = 32'hBADB_AD00;
    d_req = 1; d_we = 0; d_addr = 32'h4000;
    tick();
    chk("to_busy1", {d_ack, err}, 0);
    ticks(2);
    chk("to_busy3", {d_ack, err}, 0);
    tick();
    chk("to_ack", d_ack, 1);
    chk("to_err", err, 1);
    chk("to_stall", stall, 0);
    tick();
    chk("to_bus_error", bus_error, 1);
    chk("to_rdata_kept", d_rdata, 32'hCAFE_F00D);
    chk("to_mem_req", mem_req, 0);
    tick();
    chk("to_sticky", bus_error, 1);
    clr_error = 1;
    tick();
    clr_error = 0;
    chk("to_cleared", bus_error, 0);

    // timeout coinciding with clr_error: set wins
    clr_error = 1;
    d_req = 1; d_we = 0; d_addr = 32'h4004;
    ticks(4);
    chk("setwin_err", err, 1);
    tick();
    clr_error = 0;
    #1 chk("setwin_bus_error", bus_error, 1);
    clr_error = 1;
    tick();
    clr_error = 0;
    chk("setwin_cleared", bus_error, 0);

    // ack on the last allowed cycle beats the watchdog
    ack_at = 4; mem_rdata = 32'h5A5A_5A5A;
    d_req = 1; d_we = 0; d_addr = 32'h5000;
    ticks(4);
    chk("race_ack", d_ack, 1);
    chk("race_err", err, 0);
    tick();
    chk("race_bus_error", bus_error, 0);
    chk("race_rdata", d_rdata, 32'h5A5A_5A5A);

    // reset in the middle of a data access
    ack_at = 0; mem_rdata = 32'h600D_F00D;
    d_req = 1; d_we = 0; d_addr = 32'h6000;
    ticks(2);
    chk("rstmid_busy", mem_req, 1);
    rst = 0;
    #1;
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_no_ack", {d_ack, err}, 0);
    chk("rstmid_rdata", d_rdata, 0);
    ticks(2);
    rst = 1;
    tick();
    chk("rstmid_restart", mem_req, 1);
    chk("rstmid_addr", mem_addr, 32'h6000);
    ack_at = 2;
    tick();
    chk("rstmid_ack", d_ack, 1);
    tick();
    chk("rstmid_rdata_new", d_rdata, 32'h600D_F00D);
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
